sumador_serie: RTL and testbench

//   Bit-serial N-bit unsigned adder computing S = A + B with carry-out Cout.

---
 rtl/sumador_pkg.sv | 11 +
 rtl/sumador_serie_if.sv | 15 +
 rtl/sumador_completo.sv | 11 +
 rtl/sumador_serie.sv | 95 +++++++++
 tb/tb_sumador_serie.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sumador_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package sumador_pkg;

   // 2'd3 is unused; the FSM treats it as illegal and falls back to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUMA = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/sumador_serie_if.sv
// Start/done handshake plus operand and result buses of the serial adder.
interface sumador_serie_if #(
   parameter int N = 4
);
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic [N-1:0] S;
   logic         Cout;

   modport master (output start, A, B, input  busy, done, S, Cout);
   modport slave  (input  start, A, B, output busy, done, S, Cout);
endinterface

// File: rtl/sumador_completo.sv
// Combinational 1-bit full adder, the only arithmetic element of the serial adder.
module sumador_completo (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/sumador_serie.sv
// Bit-serial N-bit unsigned adder: one bit per clock, LSB first, through a
// single full adder, with a start/done handshake that allows chaining from FIN.
module sumador_serie
   import sumador_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   sumador_serie_if.slave bus
);
   localparam int            CW   = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t        state_q;
   logic [N-1:0]  a_q;
   logic [N-1:0]  b_q;
   logic [N-1:0]  res_q;
   logic [N-1:0]  res_d;
   logic [N-1:0]  s_q;
   logic          carry_q;
   logic          cout_q;
   logic [CW-1:0] count_q;
   logic          fa_s;
   logic          fa_cout;

   sumador_completo u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB; after N shifts the LSB has reached bit 0.
   assign res_d = N'({fa_s, res_q} >> 1);

   // NOTE: every register below is updated with <= so all of them sample the
   // pre-edge values; blocking assignments here would chain within one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         count_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.A;
                  b_q     <= bus.B;
                  carry_q <= 1'b0;
                  count_q <= '0;
                  state_q <= ST_SUMA;
               end
            end
            ST_SUMA: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= fa_cout;
               res_q   <= res_d;
               count_q <= count_q + CW'(1);
               if (count_q == LAST) begin
                  s_q     <= res_d;
                  cout_q  <= fa_cout;
                  state_q <= ST_FIN;
               end
            end
            ST_FIN: begin
               // Back-to-back: a start seen here skips the IDLE bubble.
               if (bus.start) begin
                  a_q     <= bus.A;
                  b_q     <= bus.B;
                  carry_q <= 1'b0;
                  count_q <= '0;
                  state_q <= ST_SUMA;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = (state_q == ST_SUMA);
   assign bus.done = (state_q == ST_FIN);
   assign bus.S    = s_q;
   assign bus.Cout = cout_q;

endmodule

// File: tb/tb_sumador_serie.sv
// Self-checking bench for sumador_serie (N=4): vector table, handshake corner
// cases, and a shuffled sweep of all operand pairs against plain A+B.
module tb_sumador_serie;
   localparam int N = 4;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] exp_s;
      logic         exp_cout;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   sumador_serie_if #(.N(N)) bus ();

   sumador_serie #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue one operation from IDLE and wait (bounded) for done.
   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [N-1:0] s, output logic c,
                        output int busy_cycles, output bit timed_out);
      int n;
      @(negedge clk);
      bus.A = a;
      bus.B = b;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      busy_cycles = 0;
      n = 0;
      while (!bus.done && n < 20) begin
         if (bus.busy) busy_cycles++;
         @(negedge clk);
         n++;
      end
      timed_out = !bus.done;
      s = bus.S;
      c = bus.Cout;
   endtask

   vec_t         vecs[6];
   logic [N-1:0] s_got;
   logic         c_got;
   int           bc;
   bit           to;
   logic [N:0]   ref_sum;
   int           order[256];
   int           n_wait;
   int           done_seen;

   initial begin
      checks   = 0;
      failures = 0;
      vecs[0] = '{a: 4'd3,  b: 4'd5,  exp_s: 4'd8,  exp_cout: 1'b0};
      vecs[1] = '{a: 4'd15, b: 4'd1,  exp_s: 4'd0,  exp_cout: 1'b1};
      vecs[2] = '{a: 4'd15, b: 4'd15, exp_s: 4'd14, exp_cout: 1'b1};
      vecs[3] = '{a: 4'd0,  b: 4'd0,  exp_s: 4'd0,  exp_cout: 1'b0};
      vecs[4] = '{a: 4'd10, b: 4'd7,  exp_s: 4'd1,  exp_cout: 1'b1};
      vecs[5] = '{a: 4'd6,  b: 4'd9,  exp_s: 4'd15, exp_cout: 1'b0};

      rst = 1'b1;
      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 32'(bus.busy), 0);
      check("reset_done", 32'(bus.done), 0);
      check("reset_S",    32'(bus.S),    0);
      check("reset_Cout", 32'(bus.Cout), 0);
      rst = 1'b0;

      // Vector table: result, busy length N, done pulse of width 1.
      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, s_got, c_got, bc, to);
         check($sformatf("vec%0d_timeout", i), 32'(to), 0);
         check($sformatf("vec%0d_S", i),    32'(s_got), 32'(vecs[i].exp_s));
         check($sformatf("vec%0d_Cout", i), 32'(c_got), 32'(vecs[i].exp_cout));
         check($sformatf("vec%0d_busy_cycles", i), 32'(bc), N);
         @(negedge clk);
         check($sformatf("vec%0d_done_width", i), 32'(bus.done), 0);
         check($sformatf("vec%0d_S_hold", i), 32'(bus.S), 32'(vecs[i].exp_s));
      end

      // Back-to-back: start held at FIN with A=9, B=4.
      do_op(4'd3, 4'd5, s_got, c_got, bc, to);
      check("b2b_first_S", 32'(s_got), 8);
      bus.A = 4'd9;
      bus.B = 4'd4;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_no_bubble_busy", 32'(bus.busy), 1);
      n_wait = 1;
      while (!bus.done && n_wait < 20) begin
         check("b2b_prev_S_held", 32'(bus.S), 8);
         @(negedge clk);
         n_wait++;
      end
      check("b2b_latency", 32'(n_wait), N + 1);
      check("b2b_S",    32'(bus.S),    13);
      check("b2b_Cout", 32'(bus.Cout), 0);
      @(negedge clk);

      // start pulsed and operands toggled during SUMA are ignored.
      bus.A = 4'd6;
      bus.B = 4'd7;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.A = 4'd15;
      bus.B = 4'd15;
      @(negedge clk);
      bus.start = 1'b1;
      bus.A = 4'd1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.B = 4'd2;
      n_wait = 0;
      while (!bus.done && n_wait < 20) begin
         @(negedge clk);
         n_wait++;
      end
      check("ignore_timeout", 32'(bus.done), 1);
      check("ignore_S",    32'(bus.S),    13);
      check("ignore_Cout", 32'(bus.Cout), 0);
      @(negedge clk);

      // Reset on the 2nd SUMA cycle aborts with no done.
      bus.A = 4'd15;
      bus.B = 4'd15;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check("abort_in_suma", 32'(bus.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_done", 32'(bus.done), 0);
      check("abort_S",    32'(bus.S),    0);
      check("abort_Cout", 32'(bus.Cout), 0);
      rst = 1'b0;
      done_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 0);

      // Shuffled sweep of every (A,B) pair against plain addition.
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j;
         int t;
         j = int'($urandom_range(i, 0));
         t = order[i];
         order[i] = order[j];
         order[j] = t;
      end
      for (int i = 0; i < 256; i++) begin
         logic [N-1:0] a;
         logic [N-1:0] b;
         a = N'(order[i] >> N);
         b = N'(order[i]);
         ref_sum = {1'b0, a} + {1'b0, b};
         do_op(a, b, s_got, c_got, bc, to);
         check($sformatf("sweep_%0d_%0d_timeout", a, b), 32'(to), 0);
         check($sformatf("sweep_%0d_%0d_sum", a, b), 32'({c_got, s_got}), 32'(ref_sum));
         @(negedge clk);
         check($sformatf("sweep_%0d_%0d_done_width", a, b), 32'(bus.done), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
